// File: rtl/sevenseg_pin_monitor.sv
// Multiplexed 8-digit hex display of one selectable Propeller pin bus.
// Snapshots the value once per frame; freeze holds it, dp flags a frozen frame.
module sevenseg_pin_monitor #(
  parameter int unsigned SCAN_DIV     = 16384,
  parameter int unsigned BLANK_CYCLES = 1024,
  parameter bit          LZB          = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pin_in,
  input  logic [31:0] pin_out,
  input  logic [31:0] pin_dir,
  input  logic [1:0]  sel,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   snap_q, snap_d;
  logic          frozen_q, frozen_d;
  logic          load_pend_q;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  logic        terminal, boundary, in_blank, lz_acc;
  logic [31:0] src;
  logic [3:0]  nib;
  logic [7:0]  lead_zero;

  function automatic logic [6:0] decode(input logic [3:0] v);
    unique case (v)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    terminal = (presc_q == PrescLast);
    // The first cycle out of reset counts as a frame boundary.
    boundary = load_pend_q || (terminal && (digit_q == 3'd7));
    in_blank = 32'(presc_q) < BLANK_CYCLES;

    unique case (sel)
      2'd0:    src = pin_in;
      2'd1:    src = pin_out;
      2'd2:    src = pin_dir;
      default: src = pin_out & pin_dir;
    endcase

    nib = 4'(snap_q >> {digit_q, 2'b00});

    // lead_zero[d]: every nibble at index >= d is zero; digit 0 never blanks.
    lz_acc    = 1'b1;
    lead_zero = '0;
    for (int d = 7; d >= 1; d--) begin
      lz_acc       = lz_acc && (snap_q[4*d +: 4] == 4'h0);
      lead_zero[d] = lz_acc;
    end

    presc_d  = terminal ? '0 : presc_q + 1'b1;
    digit_d  = terminal ? digit_q + 3'd1 : digit_q;
    snap_d   = (boundary && !freeze) ? src : snap_q;
    frozen_d = boundary ? freeze : frozen_q;

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!in_blank && !(LZB && lead_zero[digit_q])) begin
      an_d  = ~(8'h01 << digit_q);
      seg_d = decode(nib);
      dp_d  = !((digit_q == 3'd0) && frozen_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q     <= '0;
      digit_q     <= '0;
      snap_q      <= '0;
      frozen_q    <= 1'b0;
      load_pend_q <= 1'b1;
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      snap_q      <= snap_d;
      frozen_q    <= frozen_d;
      load_pend_q <= 1'b0;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_pin_monitor.sv
// Directed bench: two instances (LZB off/on) share inputs; every slot of
// every frame is checked against values derived from the expected snapshot.
module tb_sevenseg_pin_monitor;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pin_in = 32'h0, pin_out = 32'h0, pin_dir = 32'h0;
  logic [1:0]  sel = 2'd1;
  logic        freeze = 1'b0;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Inputs applied part-way through the next frame.
  logic [1:0]  st_sel;
  logic [31:0] st_out, st_dir;
  logic        st_freeze;

  always #5 clock = ~clock;

  sevenseg_pin_monitor #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZB(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir),
    .sel(sel), .freeze(freeze), .an(an0), .seg(seg0), .dp(dp0)
  );

  sevenseg_pin_monitor #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZB(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir),
    .sel(sel), .freeze(freeze), .an(an1), .seg(seg1), .dp(dp1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic stage(input logic [1:0] s, input logic [31:0] o, input logic [31:0] d,
                       input logic f);
    st_sel = s; st_out = o; st_dir = d; st_freeze = f;
  endtask

  // Checks k = 0..stop_k-1 of a frame expected to display val; applies staged
  // inputs right after sample mid_k.
  task automatic run_frame(input string name, input logic [31:0] val, input logic fz,
                           input int mid_k, input int stop_k);
    int unsigned p, d;
    logic [3:0]  nib;
    logic        lz_blank;
    logic [7:0]  e_an, e_an1;
    logic [6:0]  e_seg;
    logic        e_dp;
    for (int k = 0; k < 64; k++) begin
      if (k == stop_k) return;
      step();
      p   = k % SD;
      d   = k / SD;
      nib = 4'(val >> (4 * d));
      lz_blank = (d > 0) && ((val >> (4 * d)) == 32'h0);
      if (p < BC) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(8'h01 << d);
        e_seg = dec_tab[nib];
        e_dp  = !(d == 0 && fz);
      end
      e_an1 = (p < BC || lz_blank) ? 8'hFF : e_an;
      check($sformatf("%s k%0d an", name, k), 32'(an0), 32'(e_an));
      check($sformatf("%s k%0d seg", name, k), 32'(seg0), 32'(e_seg));
      check($sformatf("%s k%0d dp", name, k), 32'(dp0), 32'(e_dp));
      check($sformatf("%s k%0d lzb an", name, k), 32'(an1), 32'(e_an1));
      if (e_an1 != 8'hFF)
        check($sformatf("%s k%0d lzb seg", name, k), 32'(seg1), 32'(e_seg));
      if (k == mid_k) begin
        sel = st_sel; pin_out = st_out; pin_dir = st_dir; freeze = st_freeze;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " an"}, 32'(an0), 32'hFF);
    check({name, " seg"}, 32'(seg0), 32'h7F);
    check({name, " dp"}, 32'(dp0), 32'h1);
    check({name, " lzb an"}, 32'(an1), 32'hFF);
    check({name, " lzb seg"}, 32'(seg1), 32'h7F);
  endtask

  initial begin
    sel = 2'd1; pin_out = 32'h89AB_CDEF;
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Mid-frame bus change only shows from the next frame.
    stage(2'd1, 32'h0, 32'h0, 1'b0);
    run_frame("f1", 32'h89AB_CDEF, 1'b0, 20, 64);
    stage(2'd2, 32'h0, 32'h0000_00A0, 1'b0);
    run_frame("f2_zero", 32'h0, 1'b0, 30, 64);
    stage(2'd2, 32'h0, 32'h0000_00A0, 1'b1);
    run_frame("f3_a0", 32'h0000_00A0, 1'b0, 40, 64);
    // Frozen: sel/bus changes ignored, dp lit on digit 0.
    stage(2'd1, 32'h1234_5678, 32'h0000_00A0, 1'b1);
    run_frame("f4_frz", 32'h0000_00A0, 1'b1, 10, 64);
    stage(2'd1, 32'h1234_5678, 32'h0000_00A0, 1'b0);
    run_frame("f5_frz", 32'h0000_00A0, 1'b1, 50, 64);
    stage(2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
    run_frame("f6_unfrz", 32'h1234_5678, 1'b0, 25, 64);
    run_frame("f7_and", 32'h0F0F_0000, 1'b0, 99, 64);

    // Reset during digit 5 drive.
    run_frame("f8_part", 32'h0F0F_0000, 1'b0, 99, 44);
    reset = 1'b1;
    step();
    check_reset_outputs("midreset");
    sel = 2'd1; pin_out = 32'hDEAD_BEEF;
    reset = 1'b0;
    run_frame("f9_fresh", 32'hDEAD_BEEF, 1'b0, 99, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
